exec_commit_stage: RTL and testbench

- Stage directly downstream of the 32-bit ALU; consumes each executed instruction's aluop, result and zero/neg flags.
- Resolves branches, sequences load/store memory transactions with a request/acknowledge handshake, and drives the register-file write port.
- Retires one instruction per cycle for non-memory ops and stalls upstream with a ready signal while a memory access is outstanding.

---
 rtl/exec_commit_stage_if.sv | 46 ++++
 rtl/exec_commit_stage.sv | 191 +++++++++++++++++++
 tb/tb_exec_commit_stage.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_commit_stage_if.sv
// Execute/commit stage bundle: upstream handshake, memory request/ack port, writeback and redirect outputs.
// master = the commit stage itself, slave = the surrounding pipeline/memory/regfile.
interface exec_commit_stage_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            in_aluop;
    logic [31:0]           in_alu_out;
    logic                  in_zero;
    logic                  in_neg;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [31:0]           in_store_data;
    logic [31:0]           in_branch_target;

    logic                  mem_req;
    logic                  mem_we;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;

    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [31:0]           wb_data;

    logic                  br_taken;
    logic [31:0]           br_target;

    logic                  mem_err;
    logic [31:0]           retire_cnt;

    modport master (
        input  in_valid, in_aluop, in_alu_out, in_zero, in_neg, in_rd,
               in_store_data, in_branch_target, mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
               wb_en, wb_addr, wb_data, br_taken, br_target, mem_err, retire_cnt
    );

    modport slave (
        output in_valid, in_aluop, in_alu_out, in_zero, in_neg, in_rd,
               in_store_data, in_branch_target, mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
               wb_en, wb_addr, wb_data, br_taken, br_target, mem_err, retire_cnt
    );
endinterface

// File: rtl/exec_commit_stage.sv
// Commit stage after the ALU: writeback/branch results appear 1 cycle after accept; loads/stores hold the
// memory request until ack or timeout, and in_ready stays low for that whole window.
module exec_commit_stage #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    exec_commit_stage_if.master bus
);
    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0]  OP_BEQ   = 8'h31;
    localparam logic [7:0]  OP_BLT   = 8'h32;
    localparam logic [7:0]  OP_BGT   = 8'h33;
    localparam logic [7:0]  OP_LOAD  = 8'h41;
    localparam logic [7:0]  OP_STORE = 8'h42;
    // Abort fires on the last waiting cycle so mem_req is high exactly MEM_TIMEOUT cycles.
    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t                state_q;
    state_t                state_d;
    logic [15:0]           tmo_cnt;
    logic [REG_ADDR_W-1:0] rd_q;

    logic                  accept;
    logic                  is_wb;
    logic                  is_br;
    logic                  is_mem;
    logic                  br_hit;
    logic                  mem_done;
    logic                  mem_abort;
    logic                  retire_inc;

    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [31:0]           mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic                  wb_en_q;
    logic [REG_ADDR_W-1:0] wb_addr_q;
    logic [31:0]           wb_data_q;
    logic                  br_taken_q;
    logic [31:0]           br_target_q;
    logic                  mem_err_q;
    logic [31:0]           retire_cnt_q;

    always_comb begin
        is_wb  = ((bus.in_aluop >= 8'h10) && (bus.in_aluop <= 8'h13)) ||
                 ((bus.in_aluop >= 8'h21) && (bus.in_aluop <= 8'h27));
        is_mem = (bus.in_aluop == OP_LOAD) || (bus.in_aluop == OP_STORE);
        is_br  = 1'b0;
        br_hit = 1'b0;
        case (bus.in_aluop)
            OP_BEQ: begin
                is_br  = 1'b1;
                br_hit = bus.in_zero;
            end
            OP_BLT: begin
                is_br  = 1'b1;
                br_hit = bus.in_neg;
            end
            OP_BGT: begin
                is_br  = 1'b1;
                br_hit = !bus.in_zero && !bus.in_neg;
            end
            default: begin
                is_br  = 1'b0;
                br_hit = 1'b0;
            end
        endcase
    end

    assign bus.in_ready = (state_q == IDLE) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_done  = 1'b0;
        mem_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && is_mem) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ack) begin
                    mem_done = 1'b1;
                    state_d  = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    mem_abort = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory ops retire when the access finishes (or aborts), everything else on acceptance.
    assign retire_inc = (accept && !is_mem) || mem_done || mem_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wb_en_q      <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            br_taken_q   <= 1'b0;
            br_target_q  <= '0;
            mem_err_q    <= 1'b0;
            retire_cnt_q <= '0;
            rd_q         <= '0;
            tmo_cnt      <= '0;
        end else begin
            wb_en_q    <= 1'b0;
            br_taken_q <= 1'b0;

            if (accept) begin
                if (is_wb) begin
                    wb_en_q   <= 1'b1;
                    wb_addr_q <= bus.in_rd;
                    wb_data_q <= bus.in_alu_out;
                end
                if (is_br && br_hit) begin
                    br_taken_q  <= 1'b1;
                    br_target_q <= bus.in_branch_target;
                end
                if (is_mem) begin
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= (bus.in_aluop == OP_STORE);
                    mem_addr_q  <= bus.in_alu_out;
                    mem_wdata_q <= bus.in_store_data;
                    rd_q        <= bus.in_rd;
                    tmo_cnt     <= '0;
                end
            end

            if (mem_done) begin
                mem_req_q <= 1'b0;
                if (!mem_we_q) begin
                    wb_en_q   <= 1'b1;
                    wb_addr_q <= rd_q;
                    wb_data_q <= bus.mem_rdata;
                end
            end else if (mem_abort) begin
                mem_req_q <= 1'b0;
                mem_err_q <= 1'b1;
            end else if (state_q == MEM_WAIT) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end

            if (retire_inc) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
            end
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.wb_en      = wb_en_q;
    assign bus.wb_addr    = wb_addr_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.br_taken   = br_taken_q;
    assign bus.br_target  = br_target_q;
    assign bus.mem_err    = mem_err_q;
    assign bus.retire_cnt = retire_cnt_q;

    // A pending request must present a steady address/data/direction until it resolves.
    a_mem_stable: assert property (@(posedge clk) disable iff (rst)
        (mem_req_q && !bus.mem_ack) |=>
            ($stable(mem_addr_q) && $stable(mem_wdata_q) && $stable(mem_we_q)));

    a_pulse_excl: assert property (@(posedge clk) disable iff (rst)
        !(wb_en_q && br_taken_q));
endmodule

// File: tb/tb_exec_commit_stage.sv
// Bench for exec_commit_stage: directed plan items then random traffic against a queue-based reference model.
module tb_exec_commit_stage;
    localparam int RW  = 5;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exec_commit_stage_if #(.REG_ADDR_W(RW)) bus ();

    exec_commit_stage #(
        .REG_ADDR_W (RW),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] addr;
        logic [31:0]   data;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } mem_exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    wb_exp_t     wb_q[$];
    logic [31:0] br_q[$];
    mem_exp_t    mem_q[$];
    int unsigned exp_retire = 0;
    logic        exp_err    = 1'b0;
    logic [31:0] exp_tgt    = '0;

    bit          in_run  = 1'b0;
    int          run_len = 0;
    mem_exp_t    cur_mem;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_is_wb(input logic [7:0] op);
        return (op inside {[8'h10:8'h13]}) || (op inside {[8'h21:8'h27]});
    endfunction

    function automatic bit ref_taken(input logic [7:0] op, input logic z, input logic n);
        if (op == 8'h31) return z;
        if (op == 8'h32) return n;
        if (op == 8'h33) return !z && !n;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction; for memory ops also play the memory side (ack on the d-th request cycle,
    // or never if d exceeds the timeout).
    task automatic issue(input logic [7:0] op, input logic [RW-1:0] rd, input logic [31:0] aout,
                         input logic z, input logic n, input logic [31:0] sd,
                         input logic [31:0] tgt, input int d, input logic [31:0] rdata);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid         = 1'b1;
        bus.in_aluop         = op;
        bus.in_rd            = rd;
        bus.in_alu_out       = aout;
        bus.in_zero          = z;
        bus.in_neg           = n;
        bus.in_store_data    = sd;
        bus.in_branch_target = tgt;
        if (op == 8'h41 || op == 8'h42) begin
            mem_q.push_back('{we: (op == 8'h42), addr: aout, wdata: sd, len: (d > TMO) ? TMO : d});
        end else begin
            if (ref_is_wb(op)) wb_q.push_back('{addr: rd, data: aout});
            if (ref_taken(op, z, n)) br_q.push_back(tgt);
            exp_retire++;
        end
        tick();
        bus.in_valid = 1'b0;
        if (op == 8'h41 || op == 8'h42) begin
            if (d <= TMO) begin
                repeat (d - 1) tick();
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
                if (op == 8'h41) wb_q.push_back('{addr: rd, data: rdata});
                tick();
                bus.mem_ack = 1'b0;
            end else begin
                repeat (TMO) tick();
                exp_err = 1'b1;
            end
            exp_retire++;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        exp_retire   = 0;
        exp_err      = 1'b0;
        exp_tgt      = '0;
        repeat (cycles) tick();
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_wb_en", 32'(bus.wb_en), 32'd0);
        check("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_br_taken", 32'(bus.br_taken), 32'd0);
        check("rst_br_target", bus.br_target, 32'd0);
        check("rst_mem_err", 32'(bus.mem_err), 32'd0);
        check("rst_retire_cnt", bus.retire_cnt, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic check_status(input string tag);
        repeat (2) tick();
        check({tag, "_retire_cnt"}, bus.retire_cnt, exp_retire);
        check({tag, "_mem_err"}, 32'(bus.mem_err), 32'(exp_err));
    endtask

    // Monitor: pops expectations whenever the DUT presents a pulse or request.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_run = 1'b0;
            end else begin
                check("in_ready_vs_req", 32'(bus.in_ready), 32'(!bus.mem_req));
                if (bus.wb_en) begin
                    if (wb_q.size() == 0) begin
                        check("wb_en_unexpected", 32'(bus.wb_en), 32'd0);
                    end else begin
                        wb_exp_t e;
                        e = wb_q.pop_front();
                        check("wb_addr", 32'(bus.wb_addr), 32'(e.addr));
                        check("wb_data", bus.wb_data, e.data);
                    end
                end
                if (bus.br_taken) begin
                    if (br_q.size() == 0) begin
                        check("br_taken_unexpected", 32'(bus.br_taken), 32'd0);
                    end else begin
                        exp_tgt = br_q.pop_front();
                    end
                end
                check("br_target", bus.br_target, exp_tgt);
                if (bus.mem_req) begin
                    if (!in_run) begin
                        if (mem_q.size() == 0) begin
                            check("mem_req_unexpected", 32'(bus.mem_req), 32'd0);
                        end else begin
                            cur_mem = mem_q.pop_front();
                            in_run  = 1'b1;
                            run_len = 0;
                        end
                    end
                    if (in_run) begin
                        run_len++;
                        check("mem_we", 32'(bus.mem_we), 32'(cur_mem.we));
                        check("mem_addr", bus.mem_addr, cur_mem.addr);
                        check("mem_wdata", bus.mem_wdata, cur_mem.wdata);
                    end
                end else if (in_run) begin
                    check("mem_req_cycles", 32'(run_len), 32'(cur_mem.len));
                    in_run = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid         = 1'b0;
        bus.in_aluop         = '0;
        bus.in_alu_out       = '0;
        bus.in_zero          = 1'b0;
        bus.in_neg           = 1'b0;
        bus.in_rd            = '0;
        bus.in_store_data    = '0;
        bus.in_branch_target = '0;
        bus.mem_ack          = 1'b0;
        bus.mem_rdata        = '0;

        do_reset(3);

        issue(8'h10, 5'd3, 32'h5, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
        issue(8'h11, 5'd4, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 32'h0, 0, 32'h0);
        check_status("add_sub");

        issue(8'h31, 5'd1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h100, 0, 32'h0);
        issue(8'h32, 5'd1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h200, 0, 32'h0);
        issue(8'h33, 5'd1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h40, 0, 32'h0);
        check_status("branch");

        issue(8'h41, 5'd7, 32'h2000, 1'b0, 1'b0, 32'h0, 32'h0, 3, 32'hDEAD_BEEF);
        check("load_in_ready_after", 32'(bus.in_ready), 32'd1);
        issue(8'h42, 5'd9, 32'h10, 1'b0, 1'b0, 32'hA5A5_A5A5, 32'h0, 1, 32'h0);
        check_status("load_store");

        issue(8'h41, 5'd2, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0, TMO + 10, 32'h0);
        check_status("timeout");
        issue(8'h24, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
        check_status("after_timeout");

        // Reset while a load is outstanding; a late ack must be ignored.
        bus.in_valid   = 1'b1;
        bus.in_aluop   = 8'h41;
        bus.in_rd      = 5'd11;
        bus.in_alu_out = 32'h4444;
        mem_q.push_back('{we: 1'b0, addr: 32'h4444, wdata: bus.in_store_data, len: 0});
        tick();
        bus.in_valid = 1'b0;
        tick();
        do_reset(1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        tick();
        bus.mem_ack = 1'b0;
        check_status("rst_mid_load");

        for (int i = 0; i < 400; i++) begin
            logic [7:0]  op;
            int          cls;
            logic [7:0]  other_ops[9];
            other_ops = '{8'h00, 8'h14, 8'h20, 8'h28, 8'h30, 8'h34, 8'h40, 8'h43, 8'hFF};
            cls = $urandom_range(0, 9);
            if (cls <= 3) begin
                op = ($urandom_range(0, 1) == 0) ? 8'(8'h10 + $urandom_range(0, 3))
                                                  : 8'(8'h21 + $urandom_range(0, 6));
            end else if (cls <= 5) begin
                op = 8'(8'h31 + $urandom_range(0, 2));
            end else if (cls <= 7) begin
                op = ($urandom_range(0, 1) == 0) ? 8'h41 : 8'h42;
            end else begin
                op = other_ops[$urandom_range(0, 8)];
            end
            issue(op, RW'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom,
                  $urandom_range(1, TMO + 2), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                bus.mem_ack   = 1'($urandom);
                bus.mem_rdata = $urandom;
                tick();
                bus.mem_ack = 1'b0;
            end
        end

        repeat (6) tick();
        check("final_retire_cnt", bus.retire_cnt, exp_retire);
        check("final_mem_err", 32'(bus.mem_err), 32'(exp_err));
        check("wb_left_unseen", 32'(wb_q.size()), 32'd0);
        check("br_left_unseen", 32'(br_q.size()), 32'd0);
        check("mem_left_unseen", 32'(mem_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
